// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared constants, unit FSM states and register-index helper
package hazard_ctrl_pkg;
   localparam int REG_W = 5;
   localparam logic [5:0] OP_SPECIAL = 6'h00, OP_LB = 6'h20, OP_LBU = 6'h24;
   localparam logic [5:0] FN_MULT = 6'h18, FN_MULTU = 6'h19, FN_DIV = 6'h1a, FN_DIVU = 6'h1b;
   typedef enum logic [1:0] {IDLE, BUSY, WB} state_t;
   // Scoreboard index: FP file in the top half, so index 0 is integer r0
   function automatic logic [REG_W:0] reg_idx(input logic fp, input logic [REG_W-1:0] r);
      return {fp, r};
   endfunction
endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: 64-entry pending-write vector; integer r0 never set or matched
module reg_scoreboard
   import hazard_ctrl_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   input  logic           set_en,
   input  logic [REG_W:0] set_idx,
   input  logic           clr_en,
   input  logic [REG_W:0] clr_idx,
   input  logic [REG_W:0] a_idx,
   input  logic [REG_W:0] b_idx,
   output logic           a_hit,
   output logic           b_hit,
   output logic [63:0]    pending
);
   always_ff @(posedge clk) begin
      if (reset) pending <= '0;
      else begin
         if (clr_en) pending[clr_idx] <= 1'b0;
         if (set_en && set_idx != '0) pending[set_idx] <= 1'b1;
      end
   end
   assign a_hit = a_idx != '0 && pending[a_idx];
   assign b_hit = b_idx != '0 && pending[b_idx];
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use/RAW/WAW/structural stalls, branch flush and unit writeback freeze
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int MUL_LAT = 6,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs1,
   input  logic             id_rs1_fp,
   input  logic             id_rs1_used,
   input  logic [REG_W-1:0] id_rs2,
   input  logic             id_rs2_fp,
   input  logic             id_rs2_used,
   input  logic [REG_W-1:0] id_rd,
   input  logic             id_rd_fp,
   input  logic             id_wr_en,
   input  logic             id_is_load,
   input  logic             id_is_mul,
   input  logic             ex_taken,
   output logic             stall,
   output logic             flush,
   output logic             freeze,
   output logic             mul_start,
   output logic             mul_wb,
   output logic [REG_W-1:0] mul_rd,
   output logic             mul_rd_fp,
   output logic             mul_busy,
   output logic [CNT_W-1:0] stall_cnt
);
   state_t         state;
   logic [3:0]     cnt;
   logic           ex_ld_v;
   logic [REG_W:0] ex_ld_idx;
   logic           rs1_hit, rs2_hit;
   logic [63:0]    pending;
   logic [REG_W:0] rs1_idx, rs2_idx, rd_idx;
   logic           load_use, raw, waw, strct;
   assign rs1_idx = reg_idx(id_rs1_fp, id_rs1);
   assign rs2_idx = reg_idx(id_rs2_fp, id_rs2);
   assign rd_idx  = reg_idx(id_rd_fp, id_rd);
   reg_scoreboard u_sb (
      .clk     (clk),
      .reset   (reset),
      .set_en  (mul_start && id_wr_en),
      .set_idx (rd_idx),
      .clr_en  (mul_wb),
      .clr_idx (reg_idx(mul_rd_fp, mul_rd)),
      .a_idx   (rs1_idx),
      .b_idx   (rs2_idx),
      .a_hit   (rs1_hit),
      .b_hit   (rs2_hit),
      .pending (pending)
   );
   assign load_use  = id_valid && ex_ld_v && ((id_rs1_used && rs1_idx == ex_ld_idx) || (id_rs2_used && rs2_idx == ex_ld_idx));
   assign raw       = id_valid && ((id_rs1_used && rs1_hit) || (id_rs2_used && rs2_hit));
   assign waw       = id_valid && id_wr_en && pending[rd_idx];
   assign strct     = id_valid && id_is_mul && state != IDLE;
   assign mul_wb    = state == WB;
   assign mul_busy  = state != IDLE;
   assign freeze    = mul_wb;
   assign flush     = ex_taken && !freeze;
   assign stall     = (load_use || raw || waw || strct) && !freeze && !flush;
   assign mul_start = state == IDLE && id_valid && id_is_mul && !stall && !flush;
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         mul_rd    <= '0;
         mul_rd_fp <= 1'b0;
         ex_ld_v   <= 1'b0;
         ex_ld_idx <= '0;
         stall_cnt <= '0;
      end else begin
         stall_cnt <= stall_cnt + CNT_W'(stall || freeze);
         // A load into integer r0 never creates a load-use hazard
         if (stall || flush) begin
            ex_ld_v   <= 1'b0;
            ex_ld_idx <= '0;
         end else if (!freeze) begin
            ex_ld_v   <= id_valid && id_is_load && id_wr_en && rd_idx != '0;
            ex_ld_idx <= rd_idx;
         end
         if (mul_start) begin
            state     <= BUSY;
            cnt       <= 4'(MUL_LAT - 2);
            mul_rd    <= id_rd;
            mul_rd_fp <= id_rd_fp;
         end else if (state == BUSY) begin
            cnt <= cnt - 4'd1;
            if (cnt == '0) state <= WB;
         end else if (state == WB) state <= IDLE;
      end
   end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed test-plan sequences plus random traffic against a timestamp-based model
module tb_hazard_ctrl;
   localparam int MUL_LAT = 6;
   localparam int CNT_W   = 32;
   logic clk = 1'b0;
   logic reset;
   logic id_valid, id_rs1_fp, id_rs1_used, id_rs2_fp, id_rs2_used, id_rd_fp, id_wr_en, id_is_load, id_is_mul, ex_taken;
   logic [4:0] id_rs1, id_rs2, id_rd, mul_rd;
   logic stall, flush, freeze, mul_start, mul_wb, mul_rd_fp, mul_busy;
   logic [CNT_W-1:0] stall_cnt;
   always #5 clk = ~clk;
   hazard_ctrl #(.MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .id_valid(id_valid),
      .id_rs1(id_rs1), .id_rs1_fp(id_rs1_fp), .id_rs1_used(id_rs1_used),
      .id_rs2(id_rs2), .id_rs2_fp(id_rs2_fp), .id_rs2_used(id_rs2_used),
      .id_rd(id_rd), .id_rd_fp(id_rd_fp), .id_wr_en(id_wr_en),
      .id_is_load(id_is_load), .id_is_mul(id_is_mul), .ex_taken(ex_taken),
      .stall(stall), .flush(flush), .freeze(freeze), .mul_start(mul_start), .mul_wb(mul_wb),
      .mul_rd(mul_rd), .mul_rd_fp(mul_rd_fp), .mul_busy(mul_busy), .stall_cnt(stall_cnt)
   );
   int checks = 0, failures = 0;
   // Reference model: in-flight op is a start timestamp, scoreboard a plain bit array
   bit [63:0] pend;
   bit mv, ld_v, rand_taken;
   int t_iss, cyc;
   bit [5:0] m_dst, ld_idx;
   logic [31:0] cnt_m;
   bit e_stall, e_flush, e_freeze, e_start, e_wb, e_busy;
   function automatic bit [5:0] ix(input bit fp, input bit [4:0] r);
      return {fp, r};
   endfunction
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic model_clear();
      pend = '0; mv = 0; ld_v = 0; ld_idx = '0; t_iss = 0; cyc = 0; cnt_m = '0; m_dst = '0;
   endtask
   task automatic step();
      bit [5:0] i1, i2, id;
      bit lu, raw, waw, st;
      if (rand_taken) ex_taken = ($urandom % 8) == 0;
      #1;
      i1 = ix(id_rs1_fp, id_rs1); i2 = ix(id_rs2_fp, id_rs2); id = ix(id_rd_fp, id_rd);
      e_busy = mv;
      e_wb = mv && cyc == t_iss + MUL_LAT;
      e_freeze = e_wb;
      e_flush = ex_taken && !e_freeze;
      lu = id_valid && ld_v && ((id_rs1_used && i1 == ld_idx) || (id_rs2_used && i2 == ld_idx));
      raw = id_valid && ((id_rs1_used && pend[i1]) || (id_rs2_used && pend[i2]));
      waw = id_valid && id_wr_en && pend[id];
      st = id_valid && id_is_mul && mv;
      e_stall = (lu || raw || waw || st) && !e_freeze && !e_flush;
      e_start = !mv && id_valid && id_is_mul && !e_stall && !e_flush;
      chk("stall", stall, e_stall);
      chk("flush", flush, e_flush);
      chk("freeze", freeze, e_freeze);
      chk("mul_start", mul_start, e_start);
      chk("mul_wb", mul_wb, e_wb);
      chk("mul_busy", mul_busy, e_busy);
      chk("stall_cnt", stall_cnt, cnt_m);
      if (mv) begin
         chk("mul_rd", mul_rd, m_dst[4:0]);
         chk("mul_rd_fp", mul_rd_fp, m_dst[5]);
      end
      @(posedge clk);
      if (e_stall || e_freeze) cnt_m++;
      if (e_wb) begin mv = 0; pend[m_dst] = 0; end
      if (e_start) begin
         mv = 1; t_iss = cyc; m_dst = id;
         if (id_wr_en && id != 0) pend[id] = 1;
      end
      if (e_stall || e_flush) ld_v = 0;
      else if (!e_freeze) begin
         ld_v = id_valid && id_is_load && id_wr_en && id != 0;
         ld_idx = id;
      end
      cyc++;
      @(negedge clk);
   endtask
   task automatic set_idle();
      {id_valid, id_rs1_fp, id_rs1_used, id_rs2_fp, id_rs2_used, id_rd_fp, id_wr_en, id_is_load, id_is_mul, ex_taken} = '0;
      id_rs1 = '0; id_rs2 = '0; id_rd = '0;
   endtask
   task automatic set_ins(input bit [4:0] rs1, input bit rs1u, input bit [4:0] rs2, input bit rs2u,
                          input bit [4:0] rd, input bit wr, input bit ld, input bit mul);
      id_valid = 1; id_rs1 = rs1; id_rs1_used = rs1u; id_rs2 = rs2; id_rs2_used = rs2u;
      id_rd = rd; id_wr_en = wr; id_is_load = ld; id_is_mul = mul;
      id_rs1_fp = 0; id_rs2_fp = 0; id_rd_fp = 0;
   endtask
   // Present the ID instruction until it advances; n = extra held cycles
   task automatic run(output int n);
      n = 0;
      step();
      while ((e_stall || e_freeze) && n < 60) begin step(); n++; end
      if (n >= 60) chk("hold_bound", 32'(n), 32'd0);
   endtask
   task automatic idle(input int k);
      set_idle();
      for (int i = 0; i < k; i++) step();
   endtask
   task automatic do_reset();
      reset = 1; set_idle();
      @(posedge clk); #1 reset = 0;
      model_clear();
      @(negedge clk);
   endtask
   int n;
   initial begin
      rand_taken = 0;
      do_reset();
      chk("reset_cnt", stall_cnt, 32'd0);
      idle(2);
      // lw r3 ; add r4,r3,r5
      set_ins(5'd1, 1, 5'd0, 0, 5'd3, 1, 1, 0); run(n);
      set_ins(5'd3, 1, 5'd5, 1, 5'd4, 1, 0, 0); run(n);
      chk("lu_hold", 32'(n), 32'd1);
      chk("lu_cnt", stall_cnt, 32'd1);
      idle(1);
      // mult r6,r1,r2 ; add r7,r6,r1
      set_ins(5'd1, 1, 5'd2, 1, 5'd6, 1, 0, 1); run(n);
      set_ins(5'd6, 1, 5'd1, 1, 5'd7, 1, 0, 0); run(n);
      chk("raw_hold", 32'(n), MUL_LAT);
      // mult r6 ; mult r8 while busy
      set_ins(5'd1, 1, 5'd2, 1, 5'd6, 1, 0, 1); run(n);
      set_ins(5'd3, 1, 5'd4, 1, 5'd8, 1, 0, 1); run(n);
      chk("struct_hold", 32'(n), MUL_LAT);
      idle(MUL_LAT + 1);
      // raw stall overridden by a taken branch
      set_ins(5'd1, 1, 5'd2, 1, 5'd9, 1, 0, 1); run(n);
      set_ins(5'd9, 1, 5'd1, 1, 5'd10, 1, 0, 0); ex_taken = 1; step();
      chk("flush_wins", {flush, stall}, 32'b10);
      idle(MUL_LAT + 1);
      // lw r0 ; use r0
      set_ins(5'd1, 1, 5'd0, 0, 5'd0, 1, 1, 0); run(n);
      set_ins(5'd0, 1, 5'd0, 1, 5'd11, 1, 0, 0); run(n);
      chk("r0_nostall", 32'(n), 32'd0);
      // reset while BUSY
      set_ins(5'd1, 1, 5'd2, 1, 5'd6, 1, 0, 1); run(n);
      idle(2);
      do_reset();
      chk("rst_out", {stall, flush, freeze, mul_start, mul_wb, mul_busy}, 32'd0);
      chk("rst_cnt", stall_cnt, 32'd0);
      set_ins(5'd6, 1, 5'd6, 1, 5'd12, 1, 0, 0); run(n);
      chk("rst_pend", 32'(n), 32'd0);
      idle(MUL_LAT + 2);
      // Random traffic on a small register set to provoke hazards
      rand_taken = 1;
      for (int k = 0; k < 400; k++) begin
         id_valid = ($urandom % 8) != 0;
         id_rs1 = 5'($urandom % 4); id_rs2 = 5'($urandom % 4); id_rd = 5'($urandom % 4);
         id_rs1_fp = ($urandom % 4) == 0; id_rs2_fp = ($urandom % 4) == 0; id_rd_fp = ($urandom % 4) == 0;
         id_rs1_used = $urandom % 2; id_rs2_used = $urandom % 2;
         id_is_load = ($urandom % 4) == 0;
         id_is_mul = !id_is_load && ($urandom % 4) == 0;
         id_wr_en = ($urandom % 6) != 0;
         run(n);
      end
      rand_taken = 0;
      idle(MUL_LAT + 2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
